chain_splitter_seq: RTL and testbench

- Sequencer for the dispense direction of a serial fluid chain: splits one inlet stream into N_STAGES outlets, one outlet at a time.
- Drives the inlet valve and a one-hot outlet valve vector with programmable fill and settle timing.
- Sits between the host/test controller and the chip's valve drivers.
- Moore machine: all outputs decode from registered state only; there is no combinational path from any input to any output.

---
 rtl/chain_splitter_seq.sv | 164 ++++++++++++++++
 tb/tb_chain_splitter_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/chain_splitter_seq.sv
// Dispense-direction sequencer: one inlet stream split over N_STAGES outlets,
// one at a time. Optional per-stage skip via `CHAIN_SPLITTER_SKIP_MASK_EN.
module chain_splitter_seq #(
    parameter int N_STAGES   = 96,
    parameter int SETTLE_CYC = 4,
    parameter int VOL_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [VOL_W-1:0]    vol,
`ifdef CHAIN_SPLITTER_SKIP_MASK_EN
    input  logic [N_STAGES-1:0] skip_mask,
`endif
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                valve_in,
    output logic [N_STAGES-1:0] valve_out,
    output logic [6:0]          stage_idx
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int CNT_W = (VOL_W > SET_W) ? VOL_W : SET_W;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_FILL,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [6:0]          idx, idx_d;
    logic [VOL_W-1:0]    vol_q;
    logic [N_STAGES-1:0] skip_q;
    logic                err_q;
    logic                accept, reject, all_masked;
    logic [CNT_W-1:0]    fill_last;
    logic [6:0]          first_idx, next_idx;
    logic                next_ok;

`ifdef CHAIN_SPLITTER_SKIP_MASK_EN
    assign all_masked = &skip_mask;

    always_ff @(posedge clk) begin
        if (rst)
            skip_q <= '0;
        else if (accept)
            skip_q <= skip_mask;
    end
`else
    assign all_masked = 1'b0;
    assign skip_q     = '0;
`endif

    assign reject    = (state == S_IDLE) && start && ((vol == '0) || all_masked);
    assign accept    = (state == S_IDLE) && start && !reject;
    assign fill_last = CNT_W'(vol_q - VOL_W'(1));

    // Priority search: iterating downwards lets the lowest qualifying stage win.
    always_comb begin
        first_idx = '0;
        next_idx  = '0;
        next_ok   = 1'b0;
        for (int i = N_STAGES - 1; i >= 0; i--) begin
            if (!skip_q[i]) begin
                first_idx = 7'(i);
                if (7'(i) > idx) begin
                    next_ok  = 1'b1;
                    next_idx = 7'(i);
                end
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;

        unique case (state)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (accept)
                    state_d = S_PRIME;
            end
            S_PRIME: begin
                if (cnt == SETTLE_LAST) begin
                    state_d = S_FILL;
                    cnt_d   = '0;
                    idx_d   = first_idx;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_FILL: begin
                if (cnt == fill_last) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_d = '0;
                    if (next_ok) begin
                        state_d = S_FILL;
                        idx_d   = next_idx;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides any counter completion decided above.
        if (abort && state != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            vol_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            err_q <= reject;
            if (accept)
                vol_q <= vol;
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign err       = err_q;
    assign valve_in  = (state == S_PRIME) || (state == S_FILL);
    assign valve_out = (state == S_FILL) ? (N_STAGES'(1) << idx) : '0;
    assign stage_idx = idx;

endmodule

// File: tb/tb_chain_splitter_seq.sv
// Bench for chain_splitter_seq (N_STAGES=4, SETTLE_CYC=2): vector table driving
// full runs against a cycle-by-cycle expected-output queue, plus corner sequences.
module tb_chain_splitter_seq;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int VW = 8;

    logic           clk = 1'b0;
    logic           rst, start, abort;
    logic [VW-1:0]  vol;
`ifdef CHAIN_SPLITTER_SKIP_MASK_EN
    logic [N-1:0]   skip_mask;
`endif
    logic           busy, done, err, valve_in;
    logic [N-1:0]   valve_out;
    logic [6:0]     stage_idx;

    int n_checks = 0;
    int n_pass   = 0;

    logic [14:0] exp_q[$];

    typedef struct {
        string      name;
        int         v;
        logic [3:0] m;
        bit         rej;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    chain_splitter_seq #(.N_STAGES(N), .SETTLE_CYC(S), .VOL_W(VW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .vol       (vol),
`ifdef CHAIN_SPLITTER_SKIP_MASK_EN
        .skip_mask (skip_mask),
`endif
        .busy      (busy),
        .done      (done),
        .err       (err),
        .valve_in  (valve_in),
        .valve_out (valve_out),
        .stage_idx (stage_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    function automatic logic [14:0] pk(input logic b, input logic d, input logic e,
                                       input logic vi, input logic [3:0] vo, input int ix);
        return {b, d, e, vi, vo, 7'(ix)};
    endfunction

    function automatic logic [14:0] outs();
        return {busy, done, err, valve_in, valve_out, stage_idx};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected output for every cycle after the start cycle, through one IDLE cycle.
    task automatic push_run(input int v, input logic [3:0] m, input bit rej);
        int last;
        if (rej) begin
            exp_q.push_back(pk(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 0));
            exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 0));
            return;
        end
        last = 0;
        for (int c = 0; c < S; c++)
            exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 0));
        for (int k = 0; k < N; k++) begin
            if (m[k]) continue;
            last = k;
            for (int c = 0; c < v; c++)
                exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 1'b1, 4'(1 << k), k));
            for (int c = 0; c < S; c++)
                exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, k));
        end
        exp_q.push_back(pk(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, last));
        exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 0));
    endtask

    task automatic run_vec(input string name, input int v, input logic [3:0] m, input bit rej,
                           input int lat, input int inject_at, input bit abort_too);
        int cyc;
        int done_at;
        start = 1'b1;
        vol   = VW'(v);
        abort = abort_too;
`ifdef CHAIN_SPLITTER_SKIP_MASK_EN
        skip_mask = m;
        push_run(v, m, rej);
`else
        push_run(v, 4'h0, rej);
`endif
        cyc     = 0;
        done_at = -1;
        while (exp_q.size() > 0) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                abort = 1'b0;
            end
            if (inject_at > 0 && cyc == inject_at) begin
                start = 1'b1;
                vol   = '0;
            end
            if (inject_at > 0 && cyc == inject_at + 1)
                start = 1'b0;
            check($sformatf("%s_c%0d", name, cyc), 32'(outs()), 32'(exp_q.pop_front()));
            if (done && done_at < 0)
                done_at = cyc;
        end
        check($sformatf("%s_done_latency", name), 32'(done_at), 32'(lat));
    endtask

    initial begin
        bit found;
        int seen;

        vecs.push_back('{"v3",   3,   4'h0, 1'b0, 23});
        vecs.push_back('{"v1",   1,   4'h0, 1'b0, 15});
        vecs.push_back('{"v0",   0,   4'h0, 1'b1, -1});
        vecs.push_back('{"v5",   5,   4'h0, 1'b0, 31});
        vecs.push_back('{"vmax", 255, 4'h0, 1'b0, 1031});
`ifdef CHAIN_SPLITTER_SKIP_MASK_EN
        vecs.push_back('{"m0101", 3, 4'b0101, 1'b0, 13});
        vecs.push_back('{"m0001", 2, 4'b0001, 1'b0, 15});
        vecs.push_back('{"m1111", 3, 4'b1111, 1'b1, -1});
        skip_mask = '0;
`endif

        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        vol   = '0;
        repeat (2) tick();
        check("reset_outputs", 32'(outs()), 32'(0));
        rst = 1'b0;
        tick();
        check("idle_after_reset", 32'(outs()), 32'(0));

        foreach (vecs[i])
            run_vec(vecs[i].name, vecs[i].v, vecs[i].m, vecs[i].rej, vecs[i].lat, 0, 1'b0);

        // Abort during FILL of stage 2.
        start = 1'b1;
        vol   = 8'd3;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (valve_out == 4'b0100)
                found = 1'b1;
            else
                tick();
        end
        check("abort_reach_fill2", 32'(found), 32'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_outputs", 32'(outs()), 32'(0));
        seen = 0;
        repeat (30) begin
            tick();
            if (done || busy)
                seen++;
        end
        check("abort_no_done", 32'(seen), 32'(0));
        run_vec("after_abort", 3, 4'h0, 1'b0, 23, 0, 1'b0);

        // Reset asserted during SETTLE of stage 1.
        start = 1'b1;
        vol   = 8'd2;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (busy && !valve_in && !done && stage_idx == 7'd1)
                found = 1'b1;
            else
                tick();
        end
        check("rst_reach_settle1", 32'(found), 32'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_run_outputs", 32'(outs()), 32'(0));
        run_vec("after_rst", 2, 4'h0, 1'b0, 19, 0, 1'b0);

        // Abort alone in IDLE is ignored.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_in_idle", 32'(outs()), 32'(0));

        // A rejectable start mid-run is ignored; start+abort in IDLE is accepted.
        run_vec("midrun_start", 3, 4'h0, 1'b0, 23, 4, 1'b0);
        run_vec("start_abort", 2, 4'h0, 1'b0, 19, 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
